esc_interface: RTL and testbench



---
 rtl/esc_interface_if.sv | 19 +
 rtl/esc_interface.sv | 54 +++++
 tb/tb_esc_interface.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/esc_interface_if.sv
// Command bus between the flight-control loop and one ESC pulse generator.
// The loop drives the write strobe and speed; the generator drives the pulse.
interface esc_interface_if;
    logic        wrt;
    logic [10:0] SPEED;
    logic        PWM;

    modport master (
        output wrt,
        output SPEED,
        input  PWM
    );

    modport slave (
        input  wrt,
        input  SPEED,
        output PWM
    );
endinterface

// File: rtl/esc_interface.sv
// Single-pulse ESC command generator. A write strobe launches one high pulse
// on PWM whose width is BASE_CLKS + SPEED*SPEED_SCALE + 1 clock periods.
// A strobe during an active pulse reloads the counter without a PWM glitch.
module esc_interface #(
    parameter int BASE_CLKS   = 6250,
    parameter int SPEED_SCALE = 3,
    parameter int CNT_W       = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    esc_interface_if.slave  esc
);
    localparam logic [CNT_W-1:0] BASE_W  = CNT_W'(BASE_CLKS);
    localparam logic [CNT_W-1:0] SCALE_W = CNT_W'(SPEED_SCALE);

    logic [CNT_W-1:0] setting;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwm_q, pwm_d;

    // Pulse length from the current speed; the worst case fits in CNT_W bits.
    always_comb begin
        setting = CNT_W'(esc.SPEED) * SCALE_W + BASE_W;
    end

    // Next-state: strobe reloads and sets PWM; otherwise count down and clear at zero.
    always_comb begin
        cnt_d = cnt_q;
        pwm_d = pwm_q;
        if (esc.wrt) begin
            cnt_d = setting;
            pwm_d = 1'b1;
        end else begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (cnt_q == '0) begin
                pwm_d = 1'b0;
            end
        end
    end

    // State registers; reset aborts any pulse in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign esc.PWM = pwm_q;
endmodule

// File: tb/tb_esc_interface.sv
// Directed bench for esc_interface: pulse widths at several speeds, async
// reset mid-pulse, retrigger, held strobe and speed changes mid-pulse.
module tb_esc_interface;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    esc_interface_if bus ();

    esc_interface dut (
        .clk   (clk),
        .rst_n (rst_n),
        .esc   (bus)
    );

    always #10 clk = ~clk;

    // Counts consecutive falling edges with PWM high, starting at the current
    // falling edge; returns at the first low sample or when the bound expires.
    task automatic measure_high(input int start, output int n);
        n = start;
        while (bus.PWM === 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Drives a one-cycle strobe and leaves time at the falling edge after it.
    task automatic strobe(input logic [10:0] spd);
        @(negedge clk);
        bus.SPEED = spd;
        bus.wrt   = 1'b1;
        @(negedge clk);
        bus.wrt   = 1'b0;
    endtask

    task automatic test_reset;
        bus.wrt   = 1'b0;
        bus.SPEED = 11'd0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.PWM !== 1'b0) begin
            failures++;
            $display("FAIL reset_pwm actual=%b expected=0", bus.PWM);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.PWM !== 1'b0) begin
            failures++;
            $display("FAIL idle_pwm actual=%b expected=0", bus.PWM);
        end
        $display("test_reset done");
    endtask

    task automatic test_baseline;
        int n;
        @(negedge clk);
        checks++;
        if (bus.PWM !== 1'b0) begin
            failures++;
            $display("FAIL baseline_pre actual=%b expected=0", bus.PWM);
        end
        strobe(11'd0);
        measure_high(0, n);
        checks++;
        if (n !== 6251) begin
            failures++;
            $display("FAIL baseline_width actual=%0d expected=6251", n);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bus.PWM !== 1'b0) begin
            failures++;
            $display("FAIL baseline_stays_low actual=%b expected=0", bus.PWM);
        end
        $display("test_baseline speed=0 width=%0d", n);
    endtask

    task automatic test_max_speed;
        int n;
        strobe(11'h7FF);
        measure_high(0, n);
        checks++;
        if (n !== 12392) begin
            failures++;
            $display("FAIL max_width actual=%0d expected=12392", n);
        end
        $display("test_max_speed speed=2047 width=%0d", n);
    endtask

    task automatic test_mid_speed;
        int n;
        strobe(11'd1024);
        measure_high(0, n);
        checks++;
        if (n !== 9323) begin
            failures++;
            $display("FAIL mid_width actual=%0d expected=9323", n);
        end
        $display("test_mid_speed speed=1024 width=%0d", n);
    endtask

    task automatic test_reset_mid_pulse;
        int highs;
        highs = 0;
        strobe(11'd1024);
        for (int i = 0; i < 3000; i++) begin
            if (bus.PWM === 1'b1) highs++;
            @(negedge clk);
        end
        checks++;
        if (highs !== 3000) begin
            failures++;
            $display("FAIL rst_mid_pre_highs actual=%0d expected=3000", highs);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.PWM !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_immediate actual=%b expected=0", bus.PWM);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.PWM !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after_release actual=%b expected=0", bus.PWM);
        end
        $display("test_reset_mid_pulse pre_highs=%0d", highs);
    endtask

    task automatic test_retrigger;
        int highs;
        int n;
        highs = 0;
        strobe(11'd0);
        for (int i = 0; i < 3000; i++) begin
            if (bus.PWM === 1'b1) highs++;
            @(negedge clk);
        end
        checks++;
        if (highs !== 3000) begin
            failures++;
            $display("FAIL retrig_first_highs actual=%0d expected=3000", highs);
        end
        bus.SPEED = 11'd100;
        bus.wrt   = 1'b1;
        @(negedge clk);
        bus.wrt   = 1'b0;
        measure_high(0, n);
        checks++;
        if (n !== 6551) begin
            failures++;
            $display("FAIL retrig_width actual=%0d expected=6551", n);
        end
        $display("test_retrigger first_highs=%0d width=%0d", highs, n);
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        bus.SPEED = 11'd5;
        bus.wrt   = 1'b1;
        repeat (3) @(negedge clk);
        bus.wrt   = 1'b0;
        measure_high(0, n);
        checks++;
        if (n !== 6266) begin
            failures++;
            $display("FAIL held_wrt_width actual=%0d expected=6266", n);
        end
        $display("test_back_to_back speed=5 width=%0d", n);
    endtask

    task automatic test_speed_change;
        int n;
        strobe(11'd0);
        measure_high(0, n);
        // measure_high stops early only if PWM drops; run the first 100 cycles manually
        checks++;
        if (n !== 6251) begin
            failures++;
            $display("FAIL speed_ref_width actual=%0d expected=6251", n);
        end
        strobe(11'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.PWM === 1'b1) n++;
            @(negedge clk);
        end
        bus.SPEED = 11'd2047;
        measure_high(n, n);
        checks++;
        if (n !== 6251) begin
            failures++;
            $display("FAIL speed_change_width actual=%0d expected=6251", n);
        end
        $display("test_speed_change width=%0d", n);
    endtask

    initial begin
        bus.wrt   = 1'b0;
        bus.SPEED = 11'd0;
        test_reset();
        test_baseline();
        test_max_speed();
        test_mid_speed();
        test_reset_mid_pulse();
        test_retrigger();
        test_back_to_back();
        test_speed_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
